seq_gen: RTL
============

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: en_gen  in  1  one-cycle request to generate next round's sequence.
REQ-004 SHALL have ports: answer_seq  out  32  packed BCD sequence, 8 nibbles.
REQ-005 SHALL have ports: seq_ready  out  1  one-cycle pulse, answer_seq valid.
REQ-006 SHALL have ports: current_round  out  3  rounds started since reset, 0..7.
REQ-007 SHALL have ports: seq_len  out  4  digit count of answer_seq, 0..8.
REQ-008 SHALL have parameter: SEED, default 16'hACE1, nonzero LFSR seed.

Function
REQ-009 SHALL implement states IDLE, GEN, READY; all outputs registered.
REQ-010 SHALL run a 16-bit Fibonacci LFSR every cycle in all states, taps x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
REQ-011 SHALL, in IDLE with en_gen=1: increment current_round (saturate at 7), load seq_len = min(new_round+2, 8), clear answer_seq to 0, clear digit counter, go to GEN.
REQ-012 SHALL, in GEN, each cycle form digit d from lfsr[3:0]: d = lfsr[3:0] if <10, else lfsr[3:0]-6.
REQ-013 SHALL shift each digit in as answer_seq <= {answer_seq[27:0], d}; first digit ends in the highest used nibble, last in [3:0]; unused upper nibbles stay 0.
REQ-014 SHALL leave GEN for READY after exactly seq_len digits, then return READY->IDLE next cycle.
REQ-015 SHALL assert seq_ready only for the single cycle spent in READY; latency en_gen to seq_ready = seq_len+1 cycles.
REQ-016 SHALL hold answer_seq, seq_len stable from seq_ready until the next accepted en_gen.
REQ-017 SHALL ignore en_gen in GEN and READY (no round increment, no restart).
REQ-018 SHALL keep current_round at 7 on further accepted requests; seq_len stays 8.
REQ-019 SHALL never output a nibble above 9.

Reset
REQ-020 SHALL on rst=1, regardless of state: state IDLE, lfsr=SEED, answer_seq=0, seq_ready=0, current_round=0, seq_len=0, digit counter=0.
REQ-021 SHALL abandon a generation in progress on rst with no seq_ready pulse; first en_gen after release restarts at round 1.

Configuration
REQ-022 SHALL support macro SEQ_NO_REPEAT_EN.
REQ-023 SHALL, with SEQ_NO_REPEAT_EN defined, replace any digit equal to the previously generated digit of the same sequence by (d+1) mod 10; first digit unchanged.
REQ-024 SHALL, without SEQ_NO_REPEAT_EN, use d from REQ-012 unmodified; adjacent repeats allowed.

Verification
REQ-025 Reset held then released: all outputs 0, no seq_ready for 100 idle cycles.
REQ-026 First en_gen pulse at cycle T: current_round=1, seq_len=3, seq_ready high only at T+4, answer_seq[31:12]=0, three nibbles match LFSR reference model.
REQ-027 en_gen pulsed every cycle during GEN and READY: exactly one seq_ready, current_round incremented once.
REQ-028 Nine back-to-back accepted requests: current_round sequence 1..7,7,7; seq_len 3..8,8,8,8; all nibbles <=9.
REQ-029 rst asserted at cycle 2 of GEN: no seq_ready, outputs 0; next en_gen yields round 1, len 3, digits equal to fresh-seed model.
REQ-030 With SEQ_NO_REPEAT_EN, SEED forcing equal consecutive raw digits: no two adjacent nibbles equal; without macro, same SEED shows the repeat.

Source files
------------

// File: rtl/seq_gen.sv
// seq_gen: round-based BCD sequence generator.
// A free-running 16-bit Fibonacci LFSR supplies one digit per GEN cycle.
// Each accepted en_gen starts a new round whose sequence length is
// min(round+2, 8). The finished sequence is flagged by a one-cycle seq_ready.
// Optional feature: define SEQ_NO_REPEAT_EN to forbid equal adjacent digits.
// Handshake: en_gen is a request sampled only in IDLE; requests seen in
// GEN or READY are dropped. seq_ready is a single-cycle valid with no ready;
// answer_seq/seq_len stay stable from seq_ready until the next accepted request.
module seq_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_gen,
  output logic [31:0] answer_seq,
  output logic        seq_ready,
  output logic [2:0]  current_round,
  output logic [3:0]  seq_len,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] ans_q, ans_d;
  logic        ready_q, ready_d;
  logic [2:0]  round_q, round_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        lfsr_fb;
  logic [3:0]  raw_digit;
  logic [3:0]  digit;
  logic [3:0]  len_calc;

  // LFSR feedback and digit formation (values 10..15 fold down to 4..9)
  always_comb begin
    lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    raw_digit = (lfsr_q[3:0] < 4'd10) ? lfsr_q[3:0] : (lfsr_q[3:0] - 4'd6);
    digit     = raw_digit;
`ifdef SEQ_NO_REPEAT_EN
    // the previous digit of this sequence sits in the low nibble
    if ((cnt_q != 4'd0) && (raw_digit == ans_q[3:0])) begin
      digit = (raw_digit == 4'd9) ? 4'd0 : (raw_digit + 4'd1);
    end
`endif
  end

  // Next-state and datapath decode
  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_fb};
    ans_d    = ans_q;
    ready_d  = 1'b0;
    round_d  = round_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    len_calc = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (en_gen) begin
          round_d  = (round_q == 3'd7) ? 3'd7 : (round_q + 3'd1);
          len_calc = {1'b0, round_d} + 4'd2;
          len_d    = (len_calc > 4'd8) ? 4'd8 : len_calc;
          ans_d    = 32'd0;
          cnt_d    = 4'd0;
          state_d  = S_GEN;
        end
      end
      S_GEN: begin
        ans_d = {ans_q[27:0], digit};
        cnt_d = cnt_q + 4'd1;
        if ((cnt_q + 4'd1) == len_q) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      ans_q   <= 32'd0;
      ready_q <= 1'b0;
      round_q <= 3'd0;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ans_q   <= ans_d;
      ready_q <= ready_d;
      round_q <= round_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign answer_seq    = ans_q;
  assign seq_ready     = ready_q;
  assign current_round = round_q;
  assign seq_len       = len_q;
  assign dbg_state     = state_q;

endmodule
